ps2_frame_rx: RTL and testbench

PS/2 device-to-host frame receiver that sits directly upstream of the Spectrum key-matrix stage. It synchronises and deglitches kclk/kdat, then deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop) with parity, stop-bit and timeout checking. It absorbs the 0xF0 (release) and 0xE0 (extended) prefixes into flags and emits one qualified scancode per key event as a single-cycle strobe. The matrix stage then consumes only code/released/extended on code_valid and no longer needs its own shift register or timeout.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_frame_rx_if.sv | 30 +++
 rtl/ps2_line_filter.sv | 51 +++++
 rtl/ps2_frame_rx.sv | 168 ++++++++++++++++
 tb/tb_ps2_frame_rx.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and frame helpers for the PS/2 frame receiver.
package ps2_pkg;

    // Prefix bytes that the receiver folds into flags instead of reporting.
    localparam logic [7:0] PS2_PFX_REL   = 8'hF0;
    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    // Pause key lead-in: looks like a prefix but is passed through as a code.
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    // A frame is good when the stop bit is high and data+parity has odd weight.
    function automatic logic frame_ok(input logic [7:0] sr, input logic par, input logic stop_bit);
        return stop_bit & (^{sr, par});
    endfunction

    // True for bytes absorbed into the release/extended flags.
    function automatic logic is_prefix(input logic [7:0] b);
        return (b != PS2_PFX_PAUSE) && ((b == PS2_PFX_REL) || (b == PS2_PFX_EXT));
    endfunction

endpackage

// File: rtl/ps2_frame_rx_if.sv
// Line and result bundle of the PS/2 frame receiver.
// Handshake: code/released/extended are only meaningful in the cycle where
// code_valid is high; code_valid and frame_err are single-cycle strobes with
// no backpressure (the consumer must always accept), never high together.
interface ps2_frame_rx_if;
    import ps2_pkg::*;

    logic       kclk;
    logic       kdat;
    logic [7:0] code;
    logic       released;
    logic       extended;
    logic       code_valid;
    logic       frame_err;
    logic       busy;
    ps2_state_t dbg_state;

    // Receiver side: takes the raw lines, drives the decoded results.
    modport slave (
        input  kclk, kdat,
        output code, released, extended, code_valid, frame_err, busy, dbg_state
    );

    // Line driver / consumer side.
    modport master (
        output kclk, kdat,
        input  code, released, extended, code_valid, frame_err, busy, dbg_state
    );

endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser, stability filter and falling-edge detect for kclk.
module ps2_line_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_fall
);

    localparam logic [3:0] CNT_MAX = 4'(FILT_LEN - 1);

    logic [1:0] r_sync;
    logic [3:0] r_cnt;
    logic       r_filt;
    logic       r_fall;
    logic       w_sync;

    assign w_sync = r_sync[1];
    assign o_fall = r_fall;

    // Bring the raw line into the clock domain; idle-high line resets high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_line};
        end
    end

    // Follow the synced line only after FILT_LEN consecutive differing samples;
    // the fall strobe coincides with the cycle the filtered level drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_filt <= 1'b1;
            r_fall <= 1'b0;
        end else if (w_sync == r_filt) begin
            r_cnt  <= '0;
            r_fall <= 1'b0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt  <= '0;
            r_filt <= w_sync;
            r_fall <= ~w_sync;
        end else begin
            r_cnt  <= r_cnt + 4'd1;
            r_fall <= 1'b0;
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: deframes 11-bit frames, checks parity,
// stop bit and inactivity timeout, folds F0/E0 prefixes into flags and emits
// one qualified scancode strobe per key event.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILT_LEN  = 4,
    parameter int TOUT_BITS = 12
) (
    input  logic          clk,
    input  logic          rst,
    ps2_frame_rx_if.slave bus
);

    logic [1:0]           r_kdat_sync;
    logic                 w_kdat;
    logic                 w_fall;

    ps2_state_t           r_state,      w_state_nxt;
    logic [2:0]           r_bitcnt,     w_bitcnt_nxt;
    logic [7:0]           r_sr,         w_sr_nxt;
    logic                 r_par,        w_par_nxt;
    logic [TOUT_BITS-1:0] r_tcnt,       w_tcnt_nxt;
    logic                 r_rel_pend,   w_rel_pend_nxt;
    logic                 r_ext_pend,   w_ext_pend_nxt;
    logic [7:0]           r_code,       w_code_nxt;
    logic                 r_rel,        w_rel_nxt;
    logic                 r_ext,        w_ext_nxt;
    logic                 r_code_valid, w_code_valid_nxt;
    logic                 r_frame_err,  w_frame_err_nxt;
    logic                 w_tout;

    ps2_line_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_kclk_filt (
        .clk    (clk),
        .rst    (rst),
        .i_line (bus.kclk),
        .o_fall (w_fall)
    );

    assign w_kdat = r_kdat_sync[1];

    // Data line only needs synchronising; it is stable around kclk falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kdat_sync <= 2'b11;
        end else begin
            r_kdat_sync <= {r_kdat_sync[0], bus.kdat};
        end
    end

    assign w_tout = (r_state != IDLE) && (r_tcnt == '1);

    // Next-state, shift register, prefix flags, timeout and result strobes.
    always_comb begin
        w_state_nxt      = r_state;
        w_bitcnt_nxt     = r_bitcnt;
        w_sr_nxt         = r_sr;
        w_par_nxt        = r_par;
        w_rel_pend_nxt   = r_rel_pend;
        w_ext_pend_nxt   = r_ext_pend;
        w_code_nxt       = r_code;
        w_rel_nxt        = r_rel;
        w_ext_nxt        = r_ext;
        w_code_valid_nxt = 1'b0;
        w_frame_err_nxt  = 1'b0;

        if (w_fall || (r_state == IDLE)) begin
            w_tcnt_nxt = '0;
        end else begin
            w_tcnt_nxt = r_tcnt + 1'b1;
        end

        if (w_fall) begin
            unique case (r_state)
                IDLE: begin
                    if (!w_kdat) begin
                        w_state_nxt  = DATA;
                        w_bitcnt_nxt = 3'd0;
                    end
                end
                DATA: begin
                    w_sr_nxt     = {w_kdat, r_sr[7:1]};
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    w_par_nxt   = w_kdat;
                    w_state_nxt = STOP;
                end
                STOP: begin
                    w_state_nxt = IDLE;
                    if (frame_ok(r_sr, r_par, w_kdat)) begin
                        if (is_prefix(r_sr)) begin
                            if (r_sr == PS2_PFX_REL) begin
                                w_rel_pend_nxt = 1'b1;
                            end else begin
                                w_ext_pend_nxt = 1'b1;
                            end
                        end else begin
                            w_code_nxt       = r_sr;
                            w_rel_nxt        = r_rel_pend;
                            w_ext_nxt        = r_ext_pend;
                            w_rel_pend_nxt   = 1'b0;
                            w_ext_pend_nxt   = 1'b0;
                            w_code_valid_nxt = 1'b1;
                        end
                    end else begin
                        w_rel_pend_nxt  = 1'b0;
                        w_ext_pend_nxt  = 1'b0;
                        w_frame_err_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end else if (w_tout) begin
            // Stalled mid-frame: abandon it, report, and drop any prefix.
            w_state_nxt     = IDLE;
            w_tcnt_nxt      = '0;
            w_rel_pend_nxt  = 1'b0;
            w_ext_pend_nxt  = 1'b0;
            w_frame_err_nxt = 1'b1;
        end
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_bitcnt     <= '0;
            r_sr         <= '0;
            r_par        <= 1'b0;
            r_tcnt       <= '0;
            r_rel_pend   <= 1'b0;
            r_ext_pend   <= 1'b0;
            r_code       <= '0;
            r_rel        <= 1'b0;
            r_ext        <= 1'b0;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_sr         <= w_sr_nxt;
            r_par        <= w_par_nxt;
            r_tcnt       <= w_tcnt_nxt;
            r_rel_pend   <= w_rel_pend_nxt;
            r_ext_pend   <= w_ext_pend_nxt;
            r_code       <= w_code_nxt;
            r_rel        <= w_rel_nxt;
            r_ext        <= w_ext_nxt;
            r_code_valid <= w_code_valid_nxt;
            r_frame_err  <= w_frame_err_nxt;
        end
    end

    assign bus.code       = r_code;
    assign bus.released   = r_rel;
    assign bus.extended   = r_ext;
    assign bus.code_valid = r_code_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.busy       = (r_state != IDLE);
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Bench for ps2_frame_rx: drives PS/2 frames on the raw lines, predicts each
// strobe from a frame-level model and checks strobes in a separate monitor.
module tb_ps2_frame_rx;
    import ps2_pkg::*;

    localparam int W = 12;  // {frame_err, code_valid, extended, released, code}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ps2_frame_rx_if bus ();

    ps2_frame_rx #(
        .FILT_LEN  (4),
        .TOUT_BITS (12)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    // Frame-level model of the receiver's visible state.
    logic       m_rel, m_ext;
    logic [7:0] m_code;
    logic       m_crel, m_cext;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rel  = 1'b0;
        m_ext  = 1'b0;
        m_code = 8'h00;
        m_crel = 1'b0;
        m_cext = 1'b0;
    endtask

    task automatic model_error();
        m_rel = 1'b0;
        m_ext = 1'b0;
        exp_q.push_back({1'b1, 1'b0, m_cext, m_crel, m_code});
    endtask

    task automatic model_frame(input logic [7:0] data, input logic good);
        if (!good) begin
            model_error();
        end else if (data == 8'hF0) begin
            m_rel = 1'b1;
        end else if (data == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            m_code = data;
            m_crel = m_rel;
            m_cext = m_ext;
            m_rel  = 1'b0;
            m_ext  = 1'b0;
            exp_q.push_back({1'b0, 1'b1, m_cext, m_crel, m_code});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b, input int half);
        @(negedge clk);
        bus.kdat = b;
        repeat (half) @(negedge clk);
        bus.kclk = 1'b0;
        repeat (half) @(negedge clk);
        bus.kclk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic bad_par, input logic bad_stop);
        int   half;
        logic par;
        half = $urandom_range(6, 20);
        par  = ~(^data) ^ bad_par;
        model_frame(data, !(bad_par || bad_stop));
        send_bit(1'b0, half);
        for (int i = 0; i < 8; i++) send_bit(data[i], half);
        send_bit(par, half);
        send_bit(~bad_stop, half);
        @(negedge clk);
        bus.kdat = 1'b1;
        repeat ($urandom_range(20, 40)) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // ---------------- monitor ----------------
    logic [W-1:0] got_v, want_v;
    always @(negedge clk) begin
        if (!rst && (bus.code_valid || bus.frame_err)) begin
            got_v = {bus.frame_err, bus.code_valid, bus.extended, bus.released, bus.code};
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got %0h expected none", got_v);
            end else begin
                want_v = exp_q.pop_front();
                check("strobe", got_v, want_v);
                check("busy_at_strobe", bus.busy, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int r;
        logic [7:0] b;
        rst      = 1'b1;
        bus.kclk = 1'b1;
        bus.kdat = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        check("rst_code", bus.code, 0);
        check("rst_flags", {bus.released, bus.extended}, 0);
        check("rst_strobes", {bus.code_valid, bus.frame_err}, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Directed sequences.
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hE1, 1'b0, 1'b0);
        send_frame(8'h3A, 1'b0, 1'b1);
        wait_drain(2000, "directed_drain");

        // Timeout: prefix pending, then a frame that stops after 5 data bits.
        send_frame(8'hF0, 1'b0, 1'b0);
        model_error();
        send_bit(1'b0, 10);
        b = 8'h29;
        for (int i = 0; i < 5; i++) send_bit(b[i], 10);
        repeat (3900) @(negedge clk);
        check("tout_busy_before", bus.busy, 1);
        check("tout_not_early", exp_q.size(), 1);
        wait_drain(600, "tout_fired");
        @(negedge clk);
        check("tout_busy_after", bus.busy, 0);
        send_frame(8'h29, 1'b0, 1'b0);

        // Glitch shorter than the filter with data low must not start a frame.
        @(negedge clk);
        bus.kdat = 1'b0;
        repeat (5) @(negedge clk);
        bus.kclk = 1'b0;
        repeat (3) @(negedge clk);
        bus.kclk = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_busy", bus.busy, 0);
        bus.kdat = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h33, 1'b0, 1'b0);

        // Reset during data bit 4 with a release prefix pending.
        send_frame(8'hF0, 1'b0, 1'b0);
        b = 8'h6B;
        send_bit(1'b0, 10);
        for (int i = 0; i < 4; i++) send_bit(b[i], 10);
        @(negedge clk);
        bus.kdat = b[4];
        repeat (10) @(negedge clk);
        bus.kclk = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_outputs", {bus.code, bus.released, bus.extended, bus.code_valid, bus.frame_err}, 0);
        check("midrst_busy", bus.busy, 0);
        bus.kclk = 1'b1;
        bus.kdat = 1'b1;
        model_reset();
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b0);
        wait_drain(2000, "midrst_drain");

        // Randomised traffic with prefixes and occasional corrupt frames.
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            b = 8'($urandom_range(0, 255));
            case (r)
                0:       send_frame(8'hF0, 1'b0, 1'b0);
                1:       send_frame(8'hE0, 1'b0, 1'b0);
                2:       send_frame(b, 1'b1, 1'b0);
                3:       send_frame(b, 1'b0, 1'b1);
                default: send_frame(b, 1'b0, 1'b0);
            endcase
        end
        wait_drain(2000, "final_drain");
        check("final_busy", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
